// File: rtl/pc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_pkg
// Shared definitions for the program-counter fetch block:
//   - fetch_state_t : FSM state encoding (IDLE, RUN, HALTED)
//   - HALT_INSTR    : instruction encoding that stops a program run
//   - NOP_INSTR     : a convenient no-operation encoding
//   - branchTarget  : constant contents of the branch-target lookup table
// ---------------------------------------------------------------------------
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [8:0] HALT_INSTR  = 9'h1FF;
    localparam logic [8:0] NOP_INSTR   = 9'h000;
    localparam int         LUT_ENTRIES = 16;

    // Branch-target table contents. Most entries are 32-instruction aligned
    // subroutine slots; entry 14 points at the last ROM word and entry 15 at
    // a short in-page target. Entries are 16 bits so any PC width up to 16
    // can use the same table.
    function automatic logic [15:0] branchTarget(input logic [3:0] index);
        logic [15:0] target;
        case (index)
            4'h0:    target = 16'h0000;
            4'h1:    target = 16'h0020;
            4'h2:    target = 16'h0040;
            4'h3:    target = 16'h0060;
            4'h4:    target = 16'h0080;
            4'h5:    target = 16'h00A0;
            4'h6:    target = 16'h00C0;
            4'h7:    target = 16'h00E0;
            4'h8:    target = 16'h0100;
            4'h9:    target = 16'h0120;
            4'hA:    target = 16'h0140;
            4'hB:    target = 16'h0160;
            4'hC:    target = 16'h0180;
            4'hD:    target = 16'h01A0;
            4'hE:    target = 16'h03FF;
            default: target = 16'h0007;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut
// Read-only branch-target lookup table, purely combinational.
// Ports:
//   index  : in  4     table index (instr[3:0] of the branching instruction)
//   target : out PC_W  branch destination address
// Indices at or beyond LUT_DEPTH return address 0.
// ---------------------------------------------------------------------------
module branch_lut
    import pc_fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic [3:0]      index,
    output logic [PC_W-1:0] target
);

    // Table entries are stored 16 bits wide and trimmed to the PC width here.
    always_comb begin
        target = '0;
        if (int'(index) < LUT_DEPTH) begin
            target = PC_W'(branchTarget(index));
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Program counter and run-control FSM for a small instruction fetch path.
// Ports:
//   clk        : in  1     clock, all state changes on the rising edge
//   reset      : in  1     synchronous active-high reset
//   start      : in  1     begins a run (sampled only in IDLE or HALTED)
//   instr      : in  9     instruction read combinationally from ROM at pc
//   jumpFlag   : in  1     taken-branch indication for the instruction at pc
//   pc         : out PC_W  current instruction address
//   running    : out 1     high while in RUN
//   done       : out 1     high while in HALTED
//   instrCount : out 16    instructions retired in the current/last run
// ---------------------------------------------------------------------------
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic            jumpFlag,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done,
    output logic [15:0]     instrCount
);

    fetch_state_t    state;
    logic [PC_W-1:0] jumpTarget;

    // Branch destination for the instruction currently at pc.
    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_branch_lut (
        .index  (instr[3:0]),
        .target (jumpTarget)
    );

    // Run-control FSM, PC register and retired-instruction counter.
    // running/done are registered alongside the state so they never
    // depend combinationally on inputs. HALT is checked before jumpFlag
    // so a halting instruction always freezes pc, and every RUN cycle
    // (including the HALT cycle) retires one instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            instrCount <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (start) begin
                        state      <= RUN;
                        instrCount <= '0;
                        running    <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                RUN: begin
                    if (instrCount != 16'hFFFF) begin
                        instrCount <= instrCount + 16'd1;
                    end
                    if (instr == HALT_INSTR) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (jumpFlag) begin
                        pc <= jumpTarget;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end

                HALTED: begin
                    if (start) begin
                        state      <= RUN;
                        pc         <= '0;
                        instrCount <= '0;
                        running    <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    pc      <= '0;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
